// File: rtl/minibyte_spi_mem_if.sv
// CPU-side bus of minibyte_spi_mem: level request / one-cycle ack handshake
// with byte address, write data, read data and a halt (stall) line.
interface minibyte_spi_mem_if;
   logic       req_in;
   logic       we_in;
   logic [7:0] addr_in;
   logic [7:0] wdata_in;
   logic [7:0] rdata_out;
   logic       ack_out;
   logic       halt_out;

   // CPU side drives the request, memory side answers
   modport master (
      output req_in, we_in, addr_in, wdata_in,
      input  rdata_out, ack_out, halt_out
   );

   modport slave (
      input  req_in, we_in, addr_in, wdata_in,
      output rdata_out, ack_out, halt_out
   );
endinterface

// File: rtl/minibyte_spi_mem.sv
// minibyte_spi_mem: byte-wide CPU access to an SPI SRAM (mode 0, MSB first).
// Each access sends a 32-bit frame: command (0x03 read / 0x02 write),
// 16-bit address {0x00, addr}, then one data byte.
// Optional one-entry read cache: define MINIBYTE_SPI_MEM_RDCACHE_EN.
module minibyte_spi_mem #(
   parameter int CLK_DIV = 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              ena_in,
   minibyte_spi_mem_if.slave cpu,
   output logic              spi_cs_n_out,
   output logic              spi_sck_out,
   output logic              spi_mosi_out,
   input  logic              spi_miso_in
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   state_t      state_reg;
   state_t      state_next;
   logic [7:0]  div_cnt_reg;
   logic [3:0]  bit_cnt_reg;
   logic        sck_reg;
   logic [31:0] shift_reg;
   logic [7:0]  rx_reg;
   logic [7:0]  rdata_reg;
   logic        we_reg;

   logic        in_frame;
   logic        half_end;
   logic        phase_end;
   logic [3:0]  bit_last;
   logic        accept;
   logic        hit;
   logic        hit_take;
   logic [7:0]  cache_data;

   assign in_frame  = (state_reg == ST_CMD) || (state_reg == ST_ADDR) || (state_reg == ST_DATA);
   // a half SCK period ends; frozen entirely while ena_in is low
   assign half_end  = ena_in && in_frame && (div_cnt_reg == DIV_LAST);
   assign phase_end = half_end && sck_reg && (bit_cnt_reg == bit_last);
   assign accept    = ena_in && (state_reg == ST_IDLE) && cpu.req_in && !hit;
   assign hit_take  = ena_in && (state_reg == ST_IDLE) && cpu.req_in && hit;

   // index of the last bit of the current phase
   always_comb begin
      bit_last = 4'd0;
      case (state_reg)
         ST_CMD:  bit_last = 4'd7;
         ST_ADDR: bit_last = 4'd15;
         ST_DATA: bit_last = 4'd7;
         default: bit_last = 4'd0;
      endcase
   end

`ifdef MINIBYTE_SPI_MEM_RDCACHE_EN
   logic       cache_valid_reg;
   logic [7:0] cache_tag_reg;
   logic [7:0] cache_data_reg;
   logic [7:0] addr_reg;
   logic [7:0] wdata_reg;
   logic [7:0] tag_eq;

   for (genvar gi = 0; gi < 8; gi++) begin : g_tag_cmp
      assign tag_eq[gi] = cache_tag_reg[gi] ~^ cpu.addr_in[gi];
   end

   assign hit        = cache_valid_reg && !cpu.we_in && (&tag_eq);
   assign cache_data = cache_data_reg;

   // latch access address/data; fill on SPI read, keep coherent on write to the tag
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cache_valid_reg <= 1'b0;
         cache_tag_reg   <= 8'h00;
         cache_data_reg  <= 8'h00;
         addr_reg        <= 8'h00;
         wdata_reg       <= 8'h00;
      end else begin
         if (accept) begin
            addr_reg  <= cpu.addr_in;
            wdata_reg <= cpu.wdata_in;
         end
         if (phase_end && (state_reg == ST_DATA)) begin
            if (!we_reg) begin
               cache_valid_reg <= 1'b1;
               cache_tag_reg   <= addr_reg;
               cache_data_reg  <= rx_reg;
            end else if (cache_valid_reg && (cache_tag_reg == addr_reg)) begin
               cache_data_reg  <= wdata_reg;
            end
         end
      end
   end
`else
   assign hit        = 1'b0;
   assign cache_data = 8'h00;
`endif

   // state register
   always_ff @(posedge clk_in) begin
      if (!rst_in) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   // next-state: phases advance only at the end of their last bit
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (ena_in && cpu.req_in) state_next = hit ? ST_DONE : ST_CMD;
         ST_CMD:  if (phase_end) state_next = ST_ADDR;
         ST_ADDR: if (phase_end) state_next = ST_DATA;
         ST_DATA: if (phase_end) state_next = ST_DONE;
         ST_DONE: if (ena_in) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // SPI shifter: SCK low half with MOSI valid, MISO sampled as SCK rises
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         div_cnt_reg <= 8'h00;
         bit_cnt_reg <= 4'd0;
         sck_reg     <= 1'b0;
         shift_reg   <= 32'h0;
         rx_reg      <= 8'h00;
         we_reg      <= 1'b0;
      end else if (accept) begin
         we_reg      <= cpu.we_in;
         shift_reg   <= {cpu.we_in ? CMD_WRITE : CMD_READ, 8'h00, cpu.addr_in,
                         cpu.we_in ? cpu.wdata_in : 8'h00};
         div_cnt_reg <= 8'h00;
         bit_cnt_reg <= 4'd0;
         sck_reg     <= 1'b0;
      end else if (half_end) begin
         div_cnt_reg <= 8'h00;
         if (!sck_reg) begin
            sck_reg <= 1'b1;
            if (state_reg == ST_DATA) rx_reg <= {rx_reg[6:0], spi_miso_in};
         end else begin
            sck_reg     <= 1'b0;
            shift_reg   <= {shift_reg[30:0], 1'b0};
            bit_cnt_reg <= phase_end ? 4'd0 : bit_cnt_reg + 4'd1;
         end
      end else if (ena_in && in_frame) begin
         div_cnt_reg <= div_cnt_reg + 8'd1;
      end
   end

   // read data register: loaded at the end of an SPI read or on a cache hit
   always_ff @(posedge clk_in) begin
      if (!rst_in)                                                rdata_reg <= 8'h00;
      else if (phase_end && (state_reg == ST_DATA) && !we_reg)    rdata_reg <= rx_reg;
      else if (hit_take)                                          rdata_reg <= cache_data;
   end

   // outputs decoded from state
   always_comb begin
      spi_cs_n_out  = !in_frame;
      spi_sck_out   = sck_reg;
      spi_mosi_out  = in_frame && shift_reg[31];
      cpu.rdata_out = rdata_reg;
      cpu.ack_out   = ena_in && (state_reg == ST_DONE);
      cpu.halt_out  = ((state_reg != ST_IDLE) && (state_reg != ST_DONE)) ||
                      ((state_reg == ST_IDLE) && cpu.req_in && !hit);
   end

endmodule

// File: tb/tb_minibyte_spi_mem.sv
`timescale 1ns/1ps
// Bench for minibyte_spi_mem: SPI SRAM slave model plus a byte-array reference
// memory; directed and random accesses, freeze and mid-frame reset.
module tb_minibyte_spi_mem;
   localparam int DIV       = 3;
   localparam int FRAME_CYC = 64 * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ena   = 1'b1;
   logic cs_n, sck, mosi, miso;

   minibyte_spi_mem_if bus();

   minibyte_spi_mem #(.CLK_DIV(DIV)) dut (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .ena_in       (ena),
      .cpu          (bus.slave),
      .spi_cs_n_out (cs_n),
      .spi_sck_out  (sck),
      .spi_mosi_out (mosi),
      .spi_miso_in  (miso)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model
   logic [7:0] ref_mem [256];
   logic [7:0] ref_rdata = 8'h00;
`ifdef MINIBYTE_SPI_MEM_RDCACHE_EN
   logic       c_valid = 1'b0;
   logic [7:0] c_tag   = 8'h00;
`endif

   // SPI SRAM slave model, observed on the falling clk edge
   logic [7:0]  sram_mem [256];
   logic        sb_init     = 1'b0;
   logic        sb_prev_sck = 1'b0;
   int          sb_cyc      = 0;
   int          sb_cnt      = 0;
   int          sb_cs_low   = 0;
   int          sb_last_rise = 0;
   int          sb_gap_bad  = 0;
   logic [31:0] sb_shift    = 32'h0;
   logic [7:0]  sb_addr     = 8'h00;
   int          fr_count    = 0;
   logic [31:0] fr_word     = 32'h0;
   int          fr_cs_low   = 0;
   int          fr_gap_bad  = 0;
   logic [7:0]  miso_byte;

   always @(negedge clk) begin
      sb_cyc      <= sb_cyc + 1;
      sb_prev_sck <= sck;
      if (!sb_init) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= ref_mem[i];
         sb_init <= 1'b1;
      end else if (!cs_n) begin
         sb_cs_low <= sb_cs_low + 1;
         if (sck && !sb_prev_sck) begin
            if (sb_cnt > 0 && (sb_cyc - sb_last_rise) != 2 * DIV) sb_gap_bad <= sb_gap_bad + 1;
            sb_last_rise <= sb_cyc;
            sb_shift     <= {sb_shift[30:0], mosi};
            sb_cnt       <= sb_cnt + 1;
            if (sb_cnt == 23) sb_addr <= {sb_shift[6:0], mosi};
         end
      end else if (sb_cs_low > 0) begin
         fr_count   <= fr_count + 1;
         fr_word    <= sb_shift;
         fr_cs_low  <= sb_cs_low;
         fr_gap_bad <= sb_gap_bad;
         if (sb_cnt == 32 && sb_shift[31:24] == 8'h02) sram_mem[sb_shift[15:8]] <= sb_shift[7:0];
         sb_cnt     <= 0;
         sb_cs_low  <= 0;
         sb_gap_bad <= 0;
         sb_shift   <= 32'h0;
      end
   end

   // SRAM drives the data byte MSB first during the last 8 bits of a frame
   always_comb begin
      miso      = 1'b0;
      miso_byte = sram_mem[sb_addr];
      if (!cs_n && sb_cnt >= 24 && sb_cnt < 32) miso = miso_byte[3'(31 - sb_cnt)];
   end

   task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d, input int freeze_at);
      int          cyc;
      int          exp_ack;
      int          frames_before;
      int          halt_bad;
      int          fz_bad;
      logic        exp_hit;
      logic        fz_cs, fz_sck, fz_mosi;
      logic [31:0] exp_frame;
      exp_hit = 1'b0;
`ifdef MINIBYTE_SPI_MEM_RDCACHE_EN
      exp_hit = !w && c_valid && (c_tag == a);
`endif
      @(negedge clk);
      frames_before = fr_count;
      bus.req_in = 1'b1; bus.we_in = w; bus.addr_in = a; bus.wdata_in = d;
      #1;
      check_val("halt_req", 32'(bus.halt_out), 32'(!exp_hit));
      cyc = 0; halt_bad = 0; fz_bad = 0;
      fz_cs = 1'b1; fz_sck = 1'b0; fz_mosi = 1'b0;
      while (cyc < 2 * FRAME_CYC + 50) begin
         @(negedge clk);
         cyc++;
         if (freeze_at > 0 && cyc == freeze_at) begin
            fz_cs = cs_n; fz_sck = sck; fz_mosi = mosi;
            ena = 1'b0;
         end else if (freeze_at > 0 && cyc > freeze_at && cyc <= freeze_at + 10) begin
            if (cs_n !== fz_cs || sck !== fz_sck || mosi !== fz_mosi || bus.ack_out !== 1'b0) fz_bad++;
            if (cyc == freeze_at + 10) ena = 1'b1;
         end
         if (bus.ack_out) break;
         if (!bus.halt_out) halt_bad++;
         bus.addr_in  = 8'($urandom);
         bus.wdata_in = 8'($urandom);
      end
      exp_ack = exp_hit ? 1 : 1 + FRAME_CYC + ((freeze_at > 0) ? 10 : 0);
      check_val("ack_cycle", cyc, exp_ack);
      check_val("halt_done", 32'(bus.halt_out), 32'(1'b0));
      check_val("halt_busy", halt_bad, 0);
      if (w) begin
         ref_mem[a] = d;
      end else begin
         ref_rdata = ref_mem[a];
`ifdef MINIBYTE_SPI_MEM_RDCACHE_EN
         c_valid = 1'b1; c_tag = a;
`endif
      end
      check_val("rdata", 32'(bus.rdata_out), 32'(ref_rdata));
      bus.req_in = 1'b0;
      @(negedge clk);
      check_val("ack_pulse", 32'(bus.ack_out), 32'(1'b0));
      check_val("cs_idle", 32'(cs_n), 32'(1'b1));
      if (exp_hit) begin
         check_val("no_frame", fr_count, frames_before);
      end else begin
         exp_frame = {w ? 8'h02 : 8'h03, 8'h00, a, w ? d : 8'h00};
         check_val("frame_cnt", fr_count, frames_before + 1);
         check_val("mosi_frame", fr_word, exp_frame);
         check_val("cs_low", fr_cs_low, FRAME_CYC + ((freeze_at > 0) ? 10 : 0));
         if (freeze_at > 0) check_val("freeze", fz_bad, 0);
         else               check_val("sck_gap", fr_gap_bad, 0);
      end
      n_txn++;
      $display("TXN %0d %s addr=%02h wdata=%02h rdata=%02h ack_cyc=%0d hit=%0d",
               n_txn, w ? "WR" : "RD", a, d, bus.rdata_out, cyc, exp_hit);
   endtask

   task automatic reset_mid(input logic [7:0] a);
      int cyc;
      int acks;
      @(negedge clk);
      bus.req_in = 1'b1; bus.we_in = 1'b0; bus.addr_in = a; bus.wdata_in = 8'h00;
      cyc = 0; acks = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ack_out) acks++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_val("rst_cs", 32'(cs_n), 32'(1'b1));
      check_val("rst_sck", 32'(sck), 32'(1'b0));
      rst_n = 1'b1;
      bus.req_in = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.ack_out) acks++;
      end
      check_val("rst_no_ack", acks, 0);
      ref_rdata = 8'h00;
`ifdef MINIBYTE_SPI_MEM_RDCACHE_EN
      c_valid = 1'b0;
`endif
      check_val("rst_rdata", 32'(bus.rdata_out), 32'(ref_rdata));
      n_txn++;
      $display("TXN %0d RST addr=%02h aborted at cycle 20", n_txn, a);
   endtask

   initial begin
      logic       w;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      ref_mem[8'h3C] = 8'hA5;
      bus.req_in = 1'b0; bus.we_in = 1'b0; bus.addr_in = 8'h00; bus.wdata_in = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_cs", 32'(cs_n), 32'(1'b1));
      check_val("reset_sck", 32'(sck), 32'(1'b0));
      check_val("reset_mosi", 32'(mosi), 32'(1'b0));
      check_val("reset_ack", 32'(bus.ack_out), 32'(1'b0));
      check_val("reset_rdata", 32'(bus.rdata_out), 32'(8'h00));
      check_val("reset_halt", 32'(bus.halt_out), 32'(1'b0));
      rst_n = 1'b1;
      @(negedge clk);

      do_access(1'b0, 8'h3C, 8'h00, 0);
      do_access(1'b1, 8'h10, 8'h5E, 0);
      do_access(1'b0, 8'h10, 8'h00, 0);
      do_access(1'b0, 8'hFF, 8'h00, 0);
      do_access(1'b0, 8'h81, 8'h00, 10);
      reset_mid(8'h44);
      do_access(1'b0, 8'h44, 8'h00, 0);
      do_access(1'b0, 8'h22, 8'h00, 0);
      do_access(1'b0, 8'h22, 8'h00, 0);
      do_access(1'b1, 8'h22, 8'h77, 0);
      do_access(1'b0, 8'h22, 8'h00, 0);
      do_access(1'b1, 8'h23, 8'h19, 0);
      do_access(1'b0, 8'h22, 8'h00, 0);

      for (int n = 0; n < 24; n++) begin
         w = 1'($urandom);
         a = 8'($urandom_range(0, 7)) | 8'h60;
         do_access(w, a, 8'($urandom), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
